bill_accumulator: RTL and testbench
===================================

// Module: bill_accumulator
// PURPOSE
//  Sequential front end of the bill generator: accepts item entries (unit price, quantity) over a
//  valid/ready handshake and builds a running bill total. Each quantity unit costs one cycle and is
//  added through one instance of the 12+12->13-bit ripple adder. Carry-out is treated as overflow
//  and the total saturates. On checkout it freezes and presents the final bill.
// PARAMETERS
//  PRICE_W   12  price/total width; fixed to 12 by the adder, any other value is illegal
//  QTY_W      4  quantity width (0..15 units per entry)
//  CNT_W      8  item-entry counter width
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        asynchronous active-low reset
//  clear         in   1        synchronous clear/new bill; highest priority after rst_n
//  item_valid    in   1        item entry offered
//  item_price    in   PRICE_W  unit price of offered item
//  item_qty      in   QTY_W    quantity of offered item
//  item_ready    out  1        block can accept an entry (combinational from state)
//  checkout      in   1        close the bill
//  bill_total    out  PRICE_W  running/final total (registered)
//  bill_ovf      out  1        sticky: some addition produced carry-out
//  item_count    out  CNT_W    number of accepted non-zero-qty entries, saturating
//  bill_valid    out  1        final bill presented; high in DONE only
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, bill_total=0, bill_ovf=0, item_count=0, bill_valid=0,
//   internal price/qty regs=0; item_ready=1 once rst_n releases.
//  FSM: IDLE -> ADD -> IDLE; IDLE -> DONE; any state -> IDLE on clear.
//  IDLE: item_ready=1. Priority: clear > item handshake > checkout.
//   - item_valid & qty!=0: latch price and qty into rem_qty -> ADD.
//   - item_valid & qty==0: handshake completes, entry is dropped, count does not change, stays IDLE.
//   - checkout & !item_valid -> DONE. Checkout together with item_valid is ignored and must be re-asserted.
//  ADD: item_ready=0; checkout is ignored.
//   - Each cycle: {c,s}=adder(bill_total, price); bill_total<=c ? 12'hFFF : s; bill_ovf|=c.
//   - rem_qty decrements each cycle.
//   - In the cycle rem_qty==1: item_count++ (holds at 2^CNT_W-1) -> IDLE.
//   - Latency: an entry accepted at edge E0 updates the total at edges E1..Eq.
//     item_ready reasserts after Eq. Back-to-back entries cost q+1 cycles each.
//   - Once saturated, the total stays at 4095 (the adder still carries out, so ovf stays 1).
//  DONE: item_ready=0, bill_valid=1; total, ovf and count are frozen; item_valid and checkout are
//   ignored. Leaves only on clear or reset.
//  clear (any state, sync): next cycle state=IDLE, total=0, ovf=0, count=0, bill_valid=0.
//   Inputs sampled in the same cycle as clear are discarded; clear mid-ADD aborts the entry.
//  Async reset mid-ADD: partial total is discarded and all outputs go to reset values immediately.
//  Width rule: adder inputs are 12b. Carry (sum[12]) is only the overflow indicator and is never
//   stored as total bit.
// STRUCTURE
//  Shared package/include: state encodings ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2;
//   PRICE_W/QTY_W/CNT_W defaults; SAT_TOTAL=12'hFFF.
//  One sub-module: existing adder_1213bit, instantiated once (a=bill_total, b=price_reg).
//   No other arithmetic on the total. The count and qty counters use a plain decrementer/incrementer.
//  Registers: state, price_reg, rem_qty, bill_total, bill_ovf, item_count.
// TESTING
//  1 Reset: hold rst_n=0 with random inputs -> total=0, ovf=0, count=0, bill_valid=0;
//    item_ready=1 after release.
//  2 Entry price=100 qty=3 -> item_ready low 3 cycles, total 100,200,300 on successive edges;
//    count=1; next entry accepted on cycle 4.
//  3 Entry qty=0 price=500 -> one-cycle handshake, total and count unchanged, stays IDLE.
//  4 Saturation: price=4000 qty=2 -> total 4000 then 4095, ovf=1.
//    Further price=1 qty=1 -> total 4095, ovf stays 1.
//  5 Checkout: after 300 pulse checkout -> bill_valid=1, total=300, item_ready=0.
//    item_valid ignored. clear -> bill_valid=0, total=0 next cycle.
//  6 Disruption: clear asserted mid-ADD (price=50 qty=5, 2 adds done) -> IDLE, total=0, count=0.
//    Repeat with rst_n low mid-ADD -> immediate reset values.
//    checkout during ADD and with item_valid -> no DONE.

Source files
------------

// File: rtl/bill_accumulator_pkg.sv
// Shared definitions for the bill accumulator: width defaults, the saturation
// value of the running total and the FSM state encoding.
package bill_accumulator_pkg;

  localparam int DEF_PRICE_W = 12;  // the ripple adder is 12+12->13, so this is fixed
  localparam int DEF_QTY_W   = 4;
  localparam int DEF_CNT_W   = 8;

  localparam logic [11:0] SAT_TOTAL = 12'hFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bill_accumulator_if.sv
// Item-entry handshake bundle.
//   item_valid  master->slave  entry offered
//   item_price  master->slave  unit price
//   item_qty    master->slave  quantity (0 = entry dropped)
//   item_ready  slave->master  accumulator can take an entry this cycle
interface bill_accumulator_if
  import bill_accumulator_pkg::*;
#(
  parameter int PRICE_W = DEF_PRICE_W,
  parameter int QTY_W   = DEF_QTY_W
);

  logic               item_valid;
  logic [PRICE_W-1:0] item_price;
  logic [QTY_W-1:0]   item_qty;
  logic               item_ready;

  modport master (
    output item_valid,
    output item_price,
    output item_qty,
    input  item_ready
  );

  modport slave (
    input  item_valid,
    input  item_price,
    input  item_qty,
    output item_ready
  );

endinterface

// File: rtl/bill_accumulator_adder.sv
// adder_1213bit: 12-bit + 12-bit ripple-carry adder with 13-bit result.
//   a, b  in   12  operands
//   sum   out  13  sum[11:0] is the sum, sum[12] the carry-out
module adder_1213bit (
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [12:0] sum
);

  logic [12:0] carry;

  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < 12; gi++) begin : g_fa
    assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign sum[12] = carry[12];

endmodule

// File: rtl/bill_accumulator.sv
// bill_accumulator: accepts (price, qty) entries and builds a saturating bill
// total, adding the unit price once per cycle per quantity unit through a
// single 12-bit ripple adder. Checkout freezes the bill until clear/reset.
//   clk, rst_n    clock, asynchronous active-low reset
//   clear         synchronous new-bill, overrides everything except rst_n
//   item          slave side of the entry handshake
//   checkout      close the bill (only honoured in IDLE without item_valid)
//   bill_total    running/final total, saturates at 4095
//   bill_ovf      sticky carry-out indicator
//   item_count    accepted non-zero-qty entries, saturating
//   bill_valid    high while the final bill is presented
module bill_accumulator
  import bill_accumulator_pkg::*;
#(
  parameter int PRICE_W = DEF_PRICE_W,
  parameter int QTY_W   = DEF_QTY_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  bill_accumulator_if.slave    item,
  input  logic                 checkout,
  output logic [PRICE_W-1:0]   bill_total,
  output logic                 bill_ovf,
  output logic [CNT_W-1:0]     item_count,
  output logic                 bill_valid
);

  localparam logic [QTY_W-1:0] QTY_ONE = QTY_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t               state_reg, state_next;
  logic [PRICE_W-1:0]   price_reg, price_next;
  logic [QTY_W-1:0]     rem_qty_reg, rem_qty_next;
  logic [PRICE_W-1:0]   total_reg, total_next;
  logic                 ovf_reg, ovf_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [PRICE_W:0]     add_sum;

  // The only arithmetic on the total: total + latched unit price.
  adder_1213bit u_adder (
    .a   (total_reg),
    .b   (price_reg),
    .sum (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      price_reg   <= '0;
      rem_qty_reg <= '0;
      total_reg   <= '0;
      ovf_reg     <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      price_reg   <= price_next;
      rem_qty_reg <= rem_qty_next;
      total_reg   <= total_next;
      ovf_reg     <= ovf_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    price_next   = price_reg;
    rem_qty_next = rem_qty_reg;
    total_next   = total_reg;
    ovf_next     = ovf_reg;
    count_next   = count_reg;

    if (clear) begin
      // New bill: anything offered in this cycle is discarded, an entry in
      // progress is abandoned.
      state_next   = ST_IDLE;
      price_next   = '0;
      rem_qty_next = '0;
      total_next   = '0;
      ovf_next     = 1'b0;
      count_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (item.item_valid) begin
            // A zero-quantity entry still completes the handshake but is dropped.
            // Checkout in the same cycle loses to the entry either way.
            if (item.item_qty != '0) begin
              price_next   = item.item_price;
              rem_qty_next = item.item_qty;
              state_next   = ST_ADD;
            end
          end else if (checkout) begin
            state_next = ST_DONE;
          end
        end
        ST_ADD: begin
          // Carry-out means the true total no longer fits: pin it at the max.
          total_next   = add_sum[PRICE_W] ? SAT_TOTAL : add_sum[PRICE_W-1:0];
          ovf_next     = ovf_reg | add_sum[PRICE_W];
          rem_qty_next = rem_qty_reg - QTY_ONE;
          if (rem_qty_reg == QTY_ONE) begin
            if (count_reg != '1) begin
              count_next = count_reg + CNT_ONE;
            end
            state_next = ST_IDLE;
          end
        end
        ST_DONE: begin
          // Frozen until clear or reset.
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign item.item_ready = (state_reg == ST_IDLE);
  assign bill_total      = total_reg;
  assign bill_ovf        = ovf_reg;
  assign item_count      = count_reg;
  assign bill_valid      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_bill_accumulator.sv
module tb_bill_accumulator;
  import bill_accumulator_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        checkout;
  logic [11:0] bill_total;
  logic        bill_ovf;
  logic [7:0]  item_count;
  logic        bill_valid;

  bill_accumulator_if itf ();

  bill_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .item       (itf),
    .checkout   (checkout),
    .bill_total (bill_total),
    .bill_ovf   (bill_ovf),
    .item_count (item_count),
    .bill_valid (bill_valid)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: bill as plain integers.
  int m_total = 0;
  int m_ovf   = 0;
  int m_count = 0;

  typedef struct {
    logic        clr;
    logic        vld;
    logic [11:0] price;
    logic [3:0]  qty;
    logic        co;
    logic [11:0] total;
    logic        ovf;
    logic [7:0]  cnt;
    logic        rdy;
    logic        bv;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    itf.item_valid = 1'b0;
    itf.item_price = '0;
    itf.item_qty   = '0;
    clear          = 1'b0;
    checkout       = 1'b0;
  endtask

  task automatic offer(input int p, input int q);
    itf.item_valid = 1'b1;
    itf.item_price = 12'(p);
    itf.item_qty   = 4'(q);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    idle_inputs();
    m_total = 0; m_ovf = 0; m_count = 0;
  endtask

  // Model of one entry: the bill grows by price*qty, saturating at 4095;
  // overflow whenever the exact sum would exceed 4095.
  task automatic model_entry(input int p, input int q);
    int s;
    if (q == 0) return;
    s = m_total + p * q;
    if (s > 4095) begin
      m_total = 4095;
      m_ovf   = 1;
    end else begin
      m_total = s;
    end
    if (m_count < 255) m_count++;
  endtask

  // Offer one entry, measure how many cycles item_ready stays low, compare to model.
  task automatic do_entry(input int p, input int q, input string tag);
    int busy;
    offer(p, q);
    step();
    idle_inputs();
    busy = 0;
    while (!itf.item_ready && busy < 40) begin
      busy++;
      step();
    end
    model_entry(p, q);
    check({tag, "_busy_cycles"}, busy, q);
    check({tag, "_total"}, int'(bill_total), m_total);
    check({tag, "_ovf"}, int'(bill_ovf), m_ovf);
    check({tag, "_count"}, int'(item_count), m_count);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      itf.item_valid = 1'($urandom);
      itf.item_price = 12'($urandom);
      itf.item_qty   = 4'($urandom);
      checkout       = 1'($urandom);
      clear          = 1'($urandom);
      step();
      check("rst_total", int'(bill_total), 0);
      check("rst_ovf", int'(bill_ovf), 0);
      check("rst_count", int'(item_count), 0);
      check("rst_bill_valid", int'(bill_valid), 0);
    end
    idle_inputs();
    rst_n = 1'b1;
    step();
    check("rst_ready", int'(itf.item_ready), 1);
    check("rst_total_after", int'(bill_total), 0);

    // Table: inputs live across one edge, expectations are the outputs after it.
    //        clr   vld   price   qty   co    total   ovf   cnt  rdy   bv
    vt[0] = '{1'b0, 1'b1, 12'd100, 4'd3, 1'b0, 12'd0,   1'b0, 8'd0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 12'd0,   4'd0, 1'b0, 12'd100, 1'b0, 8'd0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b0, 12'd0,   4'd0, 1'b0, 12'd200, 1'b0, 8'd0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b0, 12'd0,   4'd0, 1'b0, 12'd300, 1'b0, 8'd1, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b1, 12'd500, 4'd0, 1'b0, 12'd300, 1'b0, 8'd1, 1'b1, 1'b0};
    vt[5] = '{1'b0, 1'b1, 12'd7,   4'd0, 1'b1, 12'd300, 1'b0, 8'd1, 1'b1, 1'b0};
    vt[6] = '{1'b0, 1'b0, 12'd0,   4'd0, 1'b1, 12'd300, 1'b0, 8'd1, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b1, 12'd5,   4'd2, 1'b1, 12'd300, 1'b0, 8'd1, 1'b0, 1'b1};
    vt[8] = '{1'b1, 1'b0, 12'd0,   4'd0, 1'b0, 12'd0,   1'b0, 8'd0, 1'b1, 1'b0};

    for (int i = 0; i < 9; i++) begin
      clear          = vt[i].clr;
      itf.item_valid = vt[i].vld;
      itf.item_price = vt[i].price;
      itf.item_qty   = vt[i].qty;
      checkout       = vt[i].co;
      step();
      check($sformatf("vec%0d_total", i), int'(bill_total), int'(vt[i].total));
      check($sformatf("vec%0d_ovf", i), int'(bill_ovf), int'(vt[i].ovf));
      check($sformatf("vec%0d_count", i), int'(item_count), int'(vt[i].cnt));
      check($sformatf("vec%0d_ready", i), int'(itf.item_ready), int'(vt[i].rdy));
      check($sformatf("vec%0d_bill_valid", i), int'(bill_valid), int'(vt[i].bv));
    end
    idle_inputs();

    // Saturation: 4000 x2 then 1 x1.
    offer(4000, 2); step(); idle_inputs();
    check("sat_accept_total", int'(bill_total), 0);
    step();
    check("sat_add1_total", int'(bill_total), 4000);
    check("sat_add1_ovf", int'(bill_ovf), 0);
    step();
    check("sat_add2_total", int'(bill_total), 4095);
    check("sat_add2_ovf", int'(bill_ovf), 1);
    check("sat_add2_ready", int'(itf.item_ready), 1);
    offer(1, 1); step(); idle_inputs(); step();
    check("sat_more_total", int'(bill_total), 4095);
    check("sat_more_ovf", int'(bill_ovf), 1);
    check("sat_more_count", int'(item_count), 2);

    // Clear in the middle of an entry.
    do_clear();
    offer(50, 5); step(); idle_inputs(); step(); step();
    check("clr_mid_partial", int'(bill_total), 100);
    clear = 1'b1; step(); idle_inputs();
    check("clr_mid_total", int'(bill_total), 0);
    check("clr_mid_count", int'(item_count), 0);
    check("clr_mid_ready", int'(itf.item_ready), 1);
    step();
    check("clr_mid_aborted", int'(bill_total), 0);

    // Async reset in the middle of an entry.
    offer(50, 1); step(); idle_inputs(); step();
    offer(50, 5); step(); idle_inputs(); step(); step();
    check("rst_mid_partial", int'(bill_total), 150);
    check("rst_mid_count_pre", int'(item_count), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_total", int'(bill_total), 0);
    check("rst_mid_count", int'(item_count), 0);
    check("rst_mid_ready", int'(itf.item_ready), 1);
    step();
    rst_n = 1'b1;
    step();

    // Checkout while adding, and together with an accepted entry.
    offer(10, 3); step(); idle_inputs();
    checkout = 1'b1;
    step(); step(); step();
    checkout = 1'b0;
    check("co_add_total", int'(bill_total), 30);
    check("co_add_bill_valid", int'(bill_valid), 0);
    check("co_add_ready", int'(itf.item_ready), 1);
    step();
    check("co_add_after", int'(bill_valid), 0);
    offer(10, 1); checkout = 1'b1; step(); idle_inputs();
    check("co_vld_bill_valid", int'(bill_valid), 0);
    check("co_vld_ready", int'(itf.item_ready), 0);
    step();
    check("co_vld_total", int'(bill_total), 40);
    check("co_vld_idle", int'(itf.item_ready), 1);

    // Randomized entries against the model.
    do_clear();
    for (int n = 0; n < 150; n++) begin
      int r, p, q;
      r = int'($urandom_range(0, 24));
      if (r == 0) begin
        do_clear();
        check("rnd_clear_total", int'(bill_total), 0);
        check("rnd_clear_count", int'(item_count), 0);
      end else if (r == 1) begin
        checkout = 1'b1; step(); idle_inputs();
        check("rnd_co_bill_valid", int'(bill_valid), 1);
        check("rnd_co_total", int'(bill_total), m_total);
        offer(int'($urandom_range(1, 4095)), int'($urandom_range(1, 15)));
        step(); idle_inputs(); step();
        check("rnd_done_frozen", int'(bill_total), m_total);
        check("rnd_done_count", int'(item_count), m_count);
        check("rnd_done_ready", int'(itf.item_ready), 0);
        do_clear();
        check("rnd_done_clear", int'(bill_valid), 0);
      end else begin
        if ($urandom_range(0, 3) == 0) p = int'($urandom_range(0, 4095));
        else                           p = int'($urandom_range(0, 300));
        q = int'($urandom_range(0, 15));
        do_entry(p, q, $sformatf("rnd%0d", n));
      end
    end

    // Item counter saturation.
    do_clear();
    for (int n = 0; n < 260; n++) begin
      do_entry(0, 1, "cnt_sat");
    end
    check("cnt_sat_final", int'(item_count), 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case something wedges the stimulus.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
